// File: rtl/pkg_amba3.sv
// Shared AXI3 types and burst helpers for the slave memory.
// Burst address stepping and response precedence live here.
package pkg_amba3;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10,
    BURST_RSVD  = 2'b11
  } burst_type_t;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } resp_type_t;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } wstate_t;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } rstate_t;

  // Callers truncate the 64-bit result to their own address width.
  function automatic logic [63:0] axi_next_addr(
    input logic [63:0]  addr,
    input logic [2:0]   size,
    input logic [3:0]   len,
    input burst_type_t  burst
  );
    logic [63:0] bytes;
    logic [63:0] nxt;
    logic [63:0] wsize;
    logic [63:0] base;
    logic [63:0] r;
    bytes = 64'd1 << size;
    nxt   = (addr & ~(bytes - 64'd1)) + bytes;
    wsize = bytes * (64'(len) + 64'd1);
    base  = addr & ~(wsize - 64'd1);
    case (burst)
      BURST_FIXED: r = addr;
      BURST_WRAP:  r = (nxt == base + wsize) ? base : nxt;
      default:     r = nxt;
    endcase
    return r;
  endfunction

  // Encoding order already matches DECERR > SLVERR > OKAY.
  function automatic resp_type_t axi_resp_max(
    input resp_type_t a,
    input resp_type_t b
  );
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/amba3_axi_addr_gen.sv
// Per-direction burst address tracker.
// Holds the current beat address and the burst-illegal flag.
module amba3_axi_addr_gen
  import pkg_amba3::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic                  advance,
  input  logic [ADDR_WIDTH-1:0] ld_addr,
  input  logic [3:0]            ld_len,
  input  logic [2:0]            ld_size,
  input  burst_type_t           ld_burst,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [ADDR_WIDTH-1:0] next_addr,
  output logic                  illegal
);

  localparam int LOG2B = $clog2(DATA_WIDTH / 8);

  logic [3:0]            len_q;
  logic [2:0]            size_q;
  burst_type_t           burst_q;
  logic                  illegal_q;
  logic                  ld_illegal;
  logic [ADDR_WIDTH-1:0] ld_mask;

  // Classify the incoming burst and step the held address.
  always_comb begin
    ld_mask    = ~({ADDR_WIDTH{1'b1}} << ld_size);
    ld_illegal = (ld_burst == BURST_RSVD)
              || (ld_size > 3'(LOG2B))
              || ((ld_burst == BURST_WRAP)
                  && !(ld_len inside {4'd1, 4'd3, 4'd7, 4'd15}))
              || ((ld_burst == BURST_WRAP)
                  && (|(ld_addr & ld_mask)));
    next_addr  = ADDR_WIDTH'(axi_next_addr(
                   64'(addr), size_q, len_q, burst_q));
    illegal    = load ? ld_illegal : illegal_q;
  end

  // Burst context register: load on address handshake, step per beat.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr      <= '0;
      len_q     <= '0;
      size_q    <= '0;
      burst_q   <= BURST_FIXED;
      illegal_q <= 1'b0;
    end else if (load) begin
      addr      <= ld_addr;
      len_q     <= ld_len;
      size_q    <= ld_size;
      burst_q   <= ld_burst;
      illegal_q <= ld_illegal;
    end else if (advance) begin
      addr      <= next_addr;
    end
  end

endmodule

// File: rtl/amba3_axi_slave_mem.sv
// AXI3 slave backed by a word-addressed memory array.
// Independent read and write FSMs, one burst in flight each.
module amba3_axi_slave_mem
  import pkg_amba3::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4,
  parameter int MEM_DEPTH  = 1024
) (
  input  logic                    aclk,
  input  logic                    areset_n,
  input  logic [ID_WIDTH-1:0]     awid,
  input  logic [ADDR_WIDTH-1:0]   awaddr,
  input  logic [3:0]              awlen,
  input  logic [2:0]              awsize,
  input  burst_type_t             awburst,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [ID_WIDTH-1:0]     wid,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    wlast,
  input  logic                    wvalid,
  output logic                    wready,
  output logic [ID_WIDTH-1:0]     bid,
  output resp_type_t              bresp,
  output logic                    bvalid,
  input  logic                    bready,
  input  logic [ID_WIDTH-1:0]     arid,
  input  logic [ADDR_WIDTH-1:0]   araddr,
  input  logic [3:0]              arlen,
  input  logic [2:0]              arsize,
  input  burst_type_t             arburst,
  input  logic                    arvalid,
  output logic                    arready,
  output logic [ID_WIDTH-1:0]     rid,
  output logic [DATA_WIDTH-1:0]   rdata,
  output resp_type_t              rresp,
  output logic                    rlast,
  output logic                    rvalid,
  input  logic                    rready
);

  localparam int STRB  = DATA_WIDTH / 8;
  localparam int LOG2B = $clog2(STRB);
  localparam int IDXW  = $clog2(MEM_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] DEPTH = ADDR_WIDTH'(MEM_DEPTH);

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  wstate_t               wstate;
  logic [3:0]            wlen_q;
  logic [3:0]            wbeat;
  logic                  wover;
  resp_type_t            wacc;
  logic [ADDR_WIDTH-1:0] wg_addr;
  logic [ADDR_WIDTH-1:0] wg_next_unused;
  logic                  wg_illegal;
  logic                  w_dec;
  logic                  w_we;
  resp_type_t            w_beat_resp;
  logic [IDXW-1:0]       w_idx;

  rstate_t               rstate;
  logic [3:0]            rlen_q;
  logic [3:0]            rbeat;
  logic [ADDR_WIDTH-1:0] rg_addr_unused;
  logic [ADDR_WIDTH-1:0] rg_next;
  logic                  rg_illegal;
  logic [ADDR_WIDTH-1:0] r_sel;
  logic                  r_dec;
  resp_type_t            r_resp;
  logic [DATA_WIDTH-1:0] r_word;
  logic [IDXW-1:0]       r_idx;

  logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic unused_wid;

  assign aw_hs      = awvalid && awready;
  assign w_hs       = wvalid && wready;
  assign b_hs       = bvalid && bready;
  assign ar_hs      = arvalid && arready;
  assign r_hs       = rvalid && rready;
  assign unused_wid = ^wid;

  amba3_axi_addr_gen #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_wgen (
    .clk      (aclk),
    .rst_n    (areset_n),
    .load     (aw_hs),
    .advance  (w_hs),
    .ld_addr  (awaddr),
    .ld_len   (awlen),
    .ld_size  (awsize),
    .ld_burst (awburst),
    .addr     (wg_addr),
    .next_addr(wg_next_unused),
    .illegal  (wg_illegal)
  );

  amba3_axi_addr_gen #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_rgen (
    .clk      (aclk),
    .rst_n    (areset_n),
    .load     (ar_hs),
    .advance  (r_hs && !rlast),
    .ld_addr  (araddr),
    .ld_len   (arlen),
    .ld_size  (arsize),
    .ld_burst (arburst),
    .addr     (rg_addr_unused),
    .next_addr(rg_next),
    .illegal  (rg_illegal)
  );

  // Per-beat write classification and memory enable.
  always_comb begin
    w_idx       = wg_addr[LOG2B +: IDXW];
    w_dec       = (wg_addr >> LOG2B) >= DEPTH;
    w_beat_resp = w_dec ? RESP_DECERR
                : (wg_illegal || wover || (wlast && wbeat != wlen_q))
                  ? RESP_SLVERR : RESP_OKAY;
    w_we        = w_hs && areset_n && !w_dec
               && !wg_illegal && !wover;
  end

  // Read beat source: AR address on load, next burst address after.
  always_comb begin
    r_sel  = (rstate == R_IDLE) ? araddr : rg_next;
    r_idx  = r_sel[LOG2B +: IDXW];
    r_dec  = (r_sel >> LOG2B) >= DEPTH;
    r_resp = r_dec ? RESP_DECERR
           : rg_illegal ? RESP_SLVERR : RESP_OKAY;
    r_word = (r_dec || rg_illegal) ? '0 : mem[r_idx];
  end

  // Byte-enabled memory write; contents survive reset.
  always_ff @(posedge aclk) begin
    if (w_we) begin
      for (int b = 0; b < STRB; b++) begin
        if (wstrb[b]) mem[w_idx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  // Write FSM: address, data beats, then response.
  always_ff @(posedge aclk) begin
    if (!areset_n) begin
      wstate  <= W_IDLE;
      awready <= 1'b0;
      wready  <= 1'b0;
      bvalid  <= 1'b0;
      bid     <= '0;
      bresp   <= RESP_OKAY;
      wlen_q  <= '0;
      wbeat   <= '0;
      wover   <= 1'b0;
      wacc    <= RESP_OKAY;
    end else begin
      unique case (wstate)
        W_IDLE: begin
          awready <= 1'b1;
          if (aw_hs) begin
            awready <= 1'b0;
            wready  <= 1'b1;
            bid     <= awid;
            wlen_q  <= awlen;
            wbeat   <= '0;
            wover   <= 1'b0;
            wacc    <= RESP_OKAY;
            wstate  <= W_DATA;
          end
        end
        W_DATA: begin
          if (w_hs) begin
            wacc  <= axi_resp_max(wacc, w_beat_resp);
            wbeat <= wbeat + 4'd1;
            if (wbeat == wlen_q && !wlast) wover <= 1'b1;
            if (wlast) begin
              wready <= 1'b0;
              bvalid <= 1'b1;
              bresp  <= axi_resp_max(wacc, w_beat_resp);
              wstate <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (b_hs) begin
            bvalid  <= 1'b0;
            awready <= 1'b1;
            wstate  <= W_IDLE;
          end
        end
        default: wstate <= W_IDLE;
      endcase
    end
  end

  // Read FSM: registered beats, next beat loaded on each handshake.
  always_ff @(posedge aclk) begin
    if (!areset_n) begin
      rstate  <= R_IDLE;
      arready <= 1'b0;
      rvalid  <= 1'b0;
      rdata   <= '0;
      rresp   <= RESP_OKAY;
      rlast   <= 1'b0;
      rid     <= '0;
      rlen_q  <= '0;
      rbeat   <= '0;
    end else begin
      unique case (rstate)
        R_IDLE: begin
          arready <= 1'b1;
          if (ar_hs) begin
            arready <= 1'b0;
            rvalid  <= 1'b1;
            rid     <= arid;
            rlen_q  <= arlen;
            rbeat   <= '0;
            rdata   <= r_word;
            rresp   <= r_resp;
            rlast   <= (arlen == 4'd0);
            rstate  <= R_DATA;
          end
        end
        R_DATA: begin
          if (r_hs) begin
            if (rlast) begin
              rvalid  <= 1'b0;
              rlast   <= 1'b0;
              arready <= 1'b1;
              rstate  <= R_IDLE;
            end else begin
              rbeat <= rbeat + 4'd1;
              rdata <= r_word;
              rresp <= r_resp;
              rlast <= ((rbeat + 4'd1) == rlen_q);
            end
          end
        end
        default: rstate <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_amba3_axi_slave_mem.sv
// Directed bench for the AXI3 slave memory.
// Acts as a simple master and checks hand-computed results.
module tb_amba3_axi_slave_mem;
  import pkg_amba3::*;

  localparam int LIM = 200;

  logic        aclk = 1'b0;
  logic        areset_n;
  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [3:0]  awlen;
  logic [2:0]  awsize;
  burst_type_t awburst;
  logic        awvalid;
  logic        awready;
  logic [3:0]  wid;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;
  logic [3:0]  bid;
  resp_type_t  bresp;
  logic        bvalid;
  logic        bready;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [3:0]  arlen;
  logic [2:0]  arsize;
  burst_type_t arburst;
  logic        arvalid;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  resp_type_t  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  int n_chk  = 0;
  int n_fail = 0;
  int n_to   = 0;

  logic [31:0] wbuf     [16];
  logic [31:0] rdq_data [16];
  logic [1:0]  rdq_resp [16];
  logic        rdq_last [16];
  int          rdq_n;
  logic        rd_lat;
  logic [3:0]  rd_id;

  always #5 aclk = ~aclk;

  amba3_axi_slave_mem dut (
    .aclk    (aclk),
    .areset_n(areset_n),
    .awid    (awid),
    .awaddr  (awaddr),
    .awlen   (awlen),
    .awsize  (awsize),
    .awburst (awburst),
    .awvalid (awvalid),
    .awready (awready),
    .wid     (wid),
    .wdata   (wdata),
    .wstrb   (wstrb),
    .wlast   (wlast),
    .wvalid  (wvalid),
    .wready  (wready),
    .bid     (bid),
    .bresp   (bresp),
    .bvalid  (bvalid),
    .bready  (bready),
    .arid    (arid),
    .araddr  (araddr),
    .arlen   (arlen),
    .arsize  (arsize),
    .arburst (arburst),
    .arvalid (arvalid),
    .arready (arready),
    .rid     (rid),
    .rdata   (rdata),
    .rresp   (rresp),
    .rlast   (rlast),
    .rvalid  (rvalid),
    .rready  (rready)
  );

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic wr_burst(input logic [3:0]  id,
                          input logic [31:0] addr,
                          input logic [3:0]  len,
                          input logic [2:0]  size,
                          input burst_type_t burst,
                          input logic [3:0]  strb,
                          input int          last_at,
                          output logic [1:0] resp,
                          output logic [3:0] id_o);
    int n;
    awid = id; awaddr = addr; awlen = len;
    awsize = size; awburst = burst; awvalid = 1'b1;
    n = 0;
    while (!awready && n < LIM) begin tick(); n++; end
    if (n >= LIM) n_to++;
    tick();
    awvalid = 1'b0;
    for (int i = 0; i <= last_at; i++) begin
      wid = id; wdata = wbuf[i]; wstrb = strb;
      wlast = (i == last_at); wvalid = 1'b1;
      n = 0;
      while (!wready && n < LIM) begin tick(); n++; end
      if (n >= LIM) n_to++;
      tick();
    end
    wvalid = 1'b0; wlast = 1'b0;
    bready = 1'b1;
    n = 0;
    while (!bvalid && n < LIM) begin tick(); n++; end
    if (n >= LIM) n_to++;
    resp = bresp;
    id_o = bid;
    tick();
    bready = 1'b0;
  endtask

  task automatic ar_send(input logic [3:0]  id,
                         input logic [31:0] addr,
                         input logic [3:0]  len,
                         input logic [2:0]  size,
                         input burst_type_t burst);
    int n;
    arid = id; araddr = addr; arlen = len;
    arsize = size; arburst = burst; arvalid = 1'b1;
    n = 0;
    while (!arready && n < LIM) begin tick(); n++; end
    if (n >= LIM) n_to++;
    tick();
    arvalid = 1'b0;
    rd_lat = rvalid;
  endtask

  task automatic rd_burst(input logic [3:0]  id,
                          input logic [31:0] addr,
                          input logic [3:0]  len,
                          input logic [2:0]  size,
                          input burst_type_t burst);
    int n;
    ar_send(id, addr, len, size, burst);
    rready = 1'b1;
    rdq_n = 0;
    for (int i = 0; i < 16; i++) begin
      n = 0;
      while (!rvalid && n < LIM) begin tick(); n++; end
      if (n >= LIM) n_to++;
      rdq_data[i] = rdata;
      rdq_resp[i] = rresp;
      rdq_last[i] = rlast;
      rd_id = rid;
      rdq_n++;
      tick();
      if (rdq_last[i] || n >= LIM) break;
    end
    rready = 1'b0;
  endtask

  initial begin
    logic [1:0]  resp;
    logic [3:0]  id_o;
    logic [31:0] exp4 [4];

    areset_n = 1'b0;
    awid = '0; awaddr = '0; awlen = '0; awsize = '0;
    awburst = BURST_FIXED; awvalid = 1'b0;
    wid = '0; wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0;
    bready = 1'b0;
    arid = '0; araddr = '0; arlen = '0; arsize = '0;
    arburst = BURST_FIXED; arvalid = 1'b0; rready = 1'b0;

    repeat (3) tick();
    chk("rst_awready", 64'(awready), 64'd0);
    chk("rst_arready", 64'(arready), 64'd0);
    chk("rst_bvalid",  64'(bvalid),  64'd0);
    chk("rst_rvalid",  64'(rvalid),  64'd0);
    areset_n = 1'b1;
    tick();
    chk("rel_awready", 64'(awready), 64'd1);
    chk("rel_arready", 64'(arready), 64'd1);

    for (int i = 0; i < 4; i++) wbuf[i] = 32'hA0 + 32'(i);
    wr_burst(4'd5, 32'h100, 4'd3, 3'd2, BURST_INCR, 4'hF, 3, resp, id_o);
    chk("incr_bresp", 64'(resp), 64'(RESP_OKAY));
    chk("incr_bid",   64'(id_o), 64'd5);
    rd_burst(4'd6, 32'h100, 4'd3, 3'd2, BURST_INCR);
    chk("incr_rlat", 64'(rd_lat), 64'd1);
    chk("incr_rid",  64'(rd_id),  64'd6);
    chk("incr_nbeat", 64'(rdq_n), 64'd4);
    for (int i = 0; i < 4; i++) begin
      chk("incr_rdata", 64'(rdq_data[i]), 64'(32'hA0 + 32'(i)));
      chk("incr_rlast", 64'(rdq_last[i]), 64'(i == 3));
      chk("incr_rresp", 64'(rdq_resp[i]), 64'(RESP_OKAY));
    end

    for (int i = 0; i < 4; i++) wbuf[i] = 32'h30 + 32'(4 * i);
    wr_burst(4'd1, 32'h30, 4'd3, 3'd2, BURST_INCR, 4'hF, 3, resp, id_o);
    chk("pre30_bresp", 64'(resp), 64'(RESP_OKAY));
    rd_burst(4'd2, 32'h38, 4'd3, 3'd2, BURST_WRAP);
    exp4 = '{32'h38, 32'h3C, 32'h30, 32'h34};
    for (int i = 0; i < 4; i++) begin
      chk("wrap_rdata", 64'(rdq_data[i]), 64'(exp4[i]));
      chk("wrap_rresp", 64'(rdq_resp[i]), 64'(RESP_OKAY));
    end
    chk("wrap_rlast", 64'(rdq_last[3]), 64'd1);

    wbuf[0] = 32'hDEAD0000;
    wbuf[1] = 32'hDEAD0001;
    wr_burst(4'd9, 32'h100, 4'd3, 3'd2, BURST_INCR, 4'hF, 1, resp, id_o);
    chk("early_bresp", 64'(resp), 64'(RESP_SLVERR));
    chk("early_bid",   64'(id_o), 64'd9);
    rd_burst(4'd3, 32'h108, 4'd1, 3'd2, BURST_INCR);
    chk("early_keep108", 64'(rdq_data[0]), 64'h0A2);
    chk("early_keep10C", 64'(rdq_data[1]), 64'h0A3);

    wbuf[0] = 32'hCAFEF00D;
    wr_burst(4'd1, 32'hFFC, 4'd0, 3'd2, BURST_INCR, 4'hF, 0, resp, id_o);
    chk("top_bresp", 64'(resp), 64'(RESP_OKAY));
    rready = 1'b0;
    ar_send(4'd4, 32'hFFC, 4'd1, 3'd2, BURST_INCR);
    for (int i = 0; i < 3; i++) begin
      chk("stall_rvalid", 64'(rvalid), 64'd1);
      chk("stall_rdata",  64'(rdata),  64'hCAFEF00D);
      tick();
    end
    chk("dec_b0_rresp", 64'(rresp), 64'(RESP_OKAY));
    chk("dec_b0_rlast", 64'(rlast), 64'd0);
    rready = 1'b1;
    tick();
    chk("dec_b1_rvalid", 64'(rvalid), 64'd1);
    chk("dec_b1_rdata",  64'(rdata),  64'd0);
    chk("dec_b1_rresp",  64'(rresp),  64'(RESP_DECERR));
    chk("dec_b1_rlast",  64'(rlast),  64'd1);
    tick();
    rready = 1'b0;
    chk("dec_done", 64'(rvalid), 64'd0);

    wbuf[0] = 32'h11223344;
    wr_burst(4'd2, 32'h200, 4'd0, 3'd2, BURST_INCR, 4'hF, 0, resp, id_o);
    wbuf[0] = 32'h0000AB00;
    wr_burst(4'd3, 32'h200, 4'd0, 3'd0, BURST_FIXED, 4'b0010, 0,
             resp, id_o);
    chk("narrow_bresp", 64'(resp), 64'(RESP_OKAY));
    rd_burst(4'd5, 32'h200, 4'd0, 3'd2, BURST_INCR);
    chk("narrow_rdata", 64'(rdq_data[0]), 64'h1122AB44);
    chk("narrow_rlast", 64'(rdq_last[0]), 64'd1);

    rd_burst(4'd4, 32'h30, 4'd2, 3'd2, BURST_WRAP);
    chk("badwrap_rresp", 64'(rdq_resp[0]), 64'(RESP_SLVERR));
    chk("badwrap_rdata", 64'(rdq_data[0]), 64'd0);
    chk("badwrap_nbeat", 64'(rdq_n), 64'd3);

    ar_send(4'd8, 32'h100, 4'd7, 3'd2, BURST_INCR);
    rready = 1'b1;
    tick();
    tick();
    chk("mid_rvalid", 64'(rvalid), 64'd1);
    areset_n = 1'b0;
    tick();
    chk("mid_rst_rvalid",  64'(rvalid),  64'd0);
    chk("mid_rst_arready", 64'(arready), 64'd0);
    rready = 1'b0;
    tick();
    areset_n = 1'b1;
    tick();
    chk("mid_rel_arready", 64'(arready), 64'd1);
    rd_burst(4'd7, 32'h30, 4'd3, 3'd2, BURST_INCR);
    for (int i = 0; i < 4; i++) begin
      chk("post_rdata", 64'(rdq_data[i]), 64'(32'h30 + 32'(4 * i)));
    end
    chk("post_rlast", 64'(rdq_last[3]), 64'd1);

    chk("timeouts", 64'(n_to), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
